// File: rtl/pdp1_tape_feeder_if.sv
// Load/read handshake bundle between the tape loader, the feeder and the reader's IOT logic.
// The master is the host/reader side; the slave is pdp1_tape_feeder.
interface pdp1_tape_feeder_if;
  logic        ld_valid;
  logic [0:7]  ld_data;
  logic        ld_ready;
  logic        ld_clear;
  logic        rd_req;
  logic        rd_bin;
  logic        rd_rewind;
  logic        rd_ack;
  logic [0:17] rd_data;
  logic        rd_eot;
  logic [0:10] tape_len;

  modport master (
    output ld_valid, ld_data, ld_clear, rd_req, rd_bin, rd_rewind,
    input  ld_ready, rd_ack, rd_data, rd_eot, tape_len
  );

  modport slave (
    input  ld_valid, ld_data, ld_clear, rd_req, rd_bin, rd_rewind,
    output ld_ready, rd_ack, rd_data, rd_eot, tape_len
  );
endinterface

// File: rtl/pdp1_tape_feeder.sv
// PDP-1 paper tape image store (1024 frames) with alpha (rpa) / binary (rpb) frame sequencer.
// Binary mode is compiled in only when PDP1_TAPE_FEEDER_BIN_EN is defined.
module pdp1_tape_feeder (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pdp1_tape_feeder_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, ACK} state_t;

  state_t      state;
  logic [0:10] wp;
  logic [0:10] rp;
  logic [0:7]  mem [0:1023];
  logic [0:7]  rd_frame;
  logic        ld_fire;

`ifdef PDP1_TAPE_FEEDER_BIN_EN
  logic        bin_mode;
  logic [1:0]  grp_cnt;
  logic [0:17] asm_word;
`else
  logic        unused_rd_bin;
  assign unused_rd_bin = bus.rd_bin;
`endif

  assign bus.ld_ready = (wp != 11'd1024) & ~bus.ld_clear;
  assign ld_fire      = bus.ld_valid & bus.ld_ready;
  assign bus.tape_len = wp;

  always_ff @(posedge i_clk) begin
    if (ld_fire)
      mem[wp[1:10]] <= bus.ld_data;
  end

  always_ff @(posedge i_clk) begin
    if (state == FETCH)
      rd_frame <= mem[rp[1:10]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      wp <= '0;
    else if (bus.ld_clear)
      wp <= '0;
    else if (ld_fire)
      wp <= wp + 11'd1;
  end

  // Empty test uses the registered wp, so a frame landing this cycle is seen on the next FETCH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      rp          <= '0;
      bus.rd_ack  <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_eot  <= 1'b0;
`ifdef PDP1_TAPE_FEEDER_BIN_EN
      bin_mode    <= 1'b0;
      grp_cnt     <= '0;
      asm_word    <= '0;
`endif
    end else if (bus.ld_clear) begin
      state      <= IDLE;
      rp         <= '0;
      bus.rd_ack <= 1'b0;
    end else begin
      bus.rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_rewind)
            rp <= '0;
          if (bus.rd_req) begin
`ifdef PDP1_TAPE_FEEDER_BIN_EN
            bin_mode <= bus.rd_bin;
            grp_cnt  <= '0;
            asm_word <= '0;
`endif
            state <= FETCH;
          end
        end
        FETCH: begin
          if (rp == wp) begin
`ifdef PDP1_TAPE_FEEDER_BIN_EN
            if (bin_mode)
              bus.rd_data <= asm_word;
`endif
            bus.rd_eot <= 1'b1;
            bus.rd_ack <= 1'b1;
            state      <= ACK;
          end else begin
            rp    <= rp + 11'd1;
            state <= EVAL;
          end
        end
        EVAL: begin
`ifdef PDP1_TAPE_FEEDER_BIN_EN
          if (bin_mode) begin
            // Frames without hole 8 are leader/blank and are skipped in binary mode.
            if (rd_frame[0]) begin
              grp_cnt <= grp_cnt + 2'd1;
              case (grp_cnt)
                2'd0: begin
                  asm_word[0:5] <= rd_frame[2:7];
                  state         <= FETCH;
                end
                2'd1: begin
                  asm_word[6:11] <= rd_frame[2:7];
                  state          <= FETCH;
                end
                default: begin
                  bus.rd_data <= {asm_word[0:11], rd_frame[2:7]};
                  bus.rd_eot  <= 1'b0;
                  bus.rd_ack  <= 1'b1;
                  state       <= ACK;
                end
              endcase
            end else begin
              state <= FETCH;
            end
          end else
`endif
          begin
            bus.rd_data <= {10'b0, rd_frame};
            bus.rd_eot  <= 1'b0;
            bus.rd_ack  <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
